// File: rtl/aes_pkg.sv
// Shared AES definitions for the decrypt datapath: block geometry, the
// InvSubBytes engine state encoding and the FIPS-197 inverse S-box table.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        ISB_IDLE = 2'd0,
        ISB_BUSY = 2'd1,
        ISB_DONE = 2'd2
    } aes_isb_state_e;

    // Inverse S-box, indexed by the substituted byte value.
    localparam logic [7:0] AES_INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    assign byte_o = AES_INV_SBOX[byte_i];

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// Iterative InvSubBytes engine: captures one 128-bit state, substitutes
// LANES bytes per clock through LANES inverse S-boxes, then holds the
// result on a valid/ready output until it is taken.
module aes_inv_sub_bytes
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);

    localparam int NGRP  = AES_NBYTES / LANES;
    localparam int CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aes_inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
    end

    aes_isb_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       work_q [AES_NBYTES];
    logic [7:0]       work_d [AES_NBYTES];
    logic [7:0]       in_bytes [AES_NBYTES];
    logic [3:0]       lane_idx [LANES];
    logic [7:0]       lane_in  [LANES];
    logic [7:0]       lane_out [LANES];
    logic             last_grp;

    // Byte i of the state lives at bits [127-8i -: 8] on both buses.
    for (genvar b = 0; b < AES_NBYTES; b++) begin : g_bytes
        assign in_bytes[b]                   = in_data[AES_BLOCK_W-1-8*b -: 8];
        assign out_data[AES_BLOCK_W-1-8*b -: 8] = work_q[b];
    end

    // One inverse S-box per lane; lane k always serves byte LANES*cnt+k.
    for (genvar k = 0; k < LANES; k++) begin : g_lanes
        aes_inv_sbox u_inv_sbox (
            .byte_i (lane_in[k]),
            .byte_o (lane_out[k])
        );
    end

    assign last_grp  = (cnt_q == CNT_W'(NGRP - 1));
    assign in_ready  = (state_q == ISB_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ISB_IDLE);

    // Select the current group of work bytes onto the S-box lanes.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_idx[k] = 4'(LANES * int'(cnt_q) + k);
            lane_in[k]  = work_q[lane_idx[k]];
        end
    end

    // Next-state logic: capture, per-group substitution, output handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        work_d      = work_q;
        case (state_q)
            ISB_IDLE: begin
                if (in_valid && in_ready) begin
                    work_d  = in_bytes;
                    cnt_d   = '0;
                    state_d = ISB_BUSY;
                end
            end
            ISB_BUSY: begin
                for (int k = 0; k < LANES; k++) begin
                    work_d[lane_idx[k]] = lane_out[k];
                end
                if (last_grp) begin
                    state_d     = ISB_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ISB_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d     = ISB_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ISB_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any partially substituted block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ISB_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            work_q      <= '{default: 8'h00};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            work_q      <= work_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Bench for aes_inv_sub_bytes: five instances (LANES = 1,2,4,8,16) fed from
// one stimulus process; expected results are queued per instance and a
// separate monitor pops and compares on every output handshake. The
// reference S-boxes are derived from GF(2^8) arithmetic and the affine map.
module tb_aes_inv_sub_bytes;

    localparam int NI = 5;

    logic         clk;
    logic         rst;
    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic [127:0] in_data   [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [127:0] out_data  [NI];
    logic         busy      [NI];

    logic [127:0] exp_q [NI][$];
    logic [7:0]   fwd_tbl [256];
    logic [7:0]   inv_tbl [256];
    int           rdy_mode;
    int           n_cmp;
    int           n_bad;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_inv_sub_bytes #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready: 0 = always ready, 1 = stalled, 2 = random.
    initial begin
        for (int i = 0; i < NI; i++) out_ready[i] = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NI; i++) begin
                case (rdy_mode)
                    0:       out_ready[i] = 1'b1;
                    1:       out_ready[i] = 1'b0;
                    default: out_ready[i] = 1'($urandom_range(0, 1));
                endcase
            end
        end
    end

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] v, int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box from its definition; the inverse is the inverse mapping.
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] xb, b, s;
            xb = 8'(x);
            b  = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(xb, 8'(y)) == 8'h01) b = 8'(y);
            s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            fwd_tbl[x] = s;
            inv_tbl[s] = xb;
        end
    endtask

    function automatic logic [127:0] model_inv(logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_tbl[d[127-8*k -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] model_fwd(logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = fwd_tbl[d[127-8*k -: 8]];
        return r;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake consumes one expected result.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (!rst && out_valid[i] === 1'b1 && out_ready[i] === 1'b1) begin
                    if (exp_q[i].size() == 0) begin
                        chk($sformatf("L%0d_unexpected_out", 1 << i), out_data[i], 128'hx);
                    end else begin
                        chk($sformatf("L%0d_out", 1 << i), out_data[i], exp_q[i].pop_front());
                    end
                end
            end
        end
    end

    // Offer one state; returns at the negedge after the acceptance edge.
    task automatic send(int i, logic [127:0] d, logic [127:0] e);
        int n = 0;
        @(negedge clk);
        while (!in_ready[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk($sformatf("L%0d_in_ready_timeout", 1 << i), 128'(n), 128'd0);
            return;
        end
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        exp_q[i].push_back(e);
        @(negedge clk);
        in_valid[i] = 1'b0;
    endtask

    // Count edges from acceptance until out_valid is seen.
    task automatic lat_chk(int i);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid[i] !== 1'b1 && n < 40);
        chk($sformatf("L%0d_latency", 1 << i), 128'(n), 128'(16 >> i));
    endtask

    task automatic drain(int i);
        int n = 0;
        while ((exp_q[i].size() != 0 || in_ready[i] !== 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("L%0d_drain", 1 << i), 128'(exp_q[i].size()), 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] held, d;
        int           n;
        n_cmp    = 0;
        n_bad    = 0;
        rdy_mode = 0;
        rst      = 1'b1;
        for (int i = 0; i < NI; i++) begin
            in_valid[i] = 1'b0;
            in_data[i]  = '0;
        end
        build_tables();

        // Reset state and release.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready[2]), 128'd0);
        chk("rst_out_valid", 128'(out_valid[2]), 128'd0);
        chk("rst_busy", 128'(busy[2]), 128'd0);
        chk("rst_out_data", out_data[2], 128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 128'(in_ready[2]), 128'd1);

        // Known vectors on LANES=4.
        send(2, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f);
        lat_chk(2);
        drain(2);
        send(2, 128'h0, {16{8'h52}});
        drain(2);
        send(2, {16{8'h16}}, {16{8'hff}});
        drain(2);

        // Output stall: result held, input ignored.
        rdy_mode = 1;
        d = {$urandom, $urandom, $urandom, $urandom};
        send(2, d, model_inv(d));
        n = 0;
        while (out_valid[2] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        held = out_data[2];
        for (int c = 0; c < 10; c++) begin
            in_valid[2] = c[0];
            in_data[2]  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("stall_out_data", out_data[2], held);
            chk("stall_in_ready", 128'(in_ready[2]), 128'd0);
        end
        chk("stall_out_valid", 128'(out_valid[2]), 128'd1);
        in_valid[2] = 1'b0;
        rdy_mode = 0;
        n = 0;
        while (out_ready[2] !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("post_hs_busy", 128'(busy[2]), 128'd0);
        chk("post_hs_in_ready", 128'(in_ready[2]), 128'd1);
        chk("post_hs_out_data", out_data[2], model_inv(d));
        drain(2);

        // Asynchronous reset in the middle of BUSY (cnt=2).
        d = {$urandom, $urandom, $urandom, $urandom};
        send(2, d, model_inv(d));
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        void'(exp_q[2].pop_back());
        #1;
        chk("abort_in_ready", 128'(in_ready[2]), 128'd0);
        chk("abort_busy", 128'(busy[2]), 128'd0);
        chk("abort_out_valid", 128'(out_valid[2]), 128'd0);
        chk("abort_out_data", out_data[2], 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rel_in_ready", 128'(in_ready[2]), 128'd1);
        send(2, 128'h0, {16{8'h52}});
        drain(2);

        // Every lane width: latency and random states under random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < NI; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            send(i, d, model_inv(d));
            lat_chk(i);
            for (int t = 0; t < 20; t++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                send(i, d, model_inv(d));
            end
            drain(i);
        end

        // Forward S-box chained in: all 256 byte values must round-trip.
        rdy_mode = 0;
        for (int i = 0; i < NI; i++) begin
            for (int s = 0; s < 16; s++) begin
                for (int k = 0; k < 16; k++) d[127-8*k -: 8] = 8'(s * 16 + k);
                send(i, model_fwd(d), d);
            end
            drain(i);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
